// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator driven by a commanded edge period and direction, with a signed position count.
// Define QUAD_ENCODER_INDEX_EN to add the enc_z index output (one phase state per CPR edges).
module quad_encoder_emulator #(
    parameter int DIV_W      = 24,
    parameter int MIN_PERIOD = 2500,
    parameter int POS_W      = 36,
    parameter int CPR        = 1200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic [DIV_W-1:0]        cmd_period,
    input  logic                    cmd_dir,
    input  logic                    cmd_en,
    output logic                    cmd_ack,
    output logic                    enc_a,
    output logic                    enc_b,
    output logic                    step,
    output logic signed [POS_W-1:0] position,
`ifdef QUAD_ENCODER_INDEX_EN
    output logic                    enc_z,
`endif
    output logic                    running
);

    if (CPR < 2 || MIN_PERIOD < 1) begin : g_param_check
        $error("quad_encoder_emulator: CPR must be >= 2 and MIN_PERIOD >= 1");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [1:0]              phase_q, phase_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0]        act_period_q, act_period_d;
    logic                    act_dir_q, act_dir_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0]        pend_period_q, pend_period_d;
    logic                    pend_dir_q, pend_dir_d;
    logic                    pend_en_q, pend_en_d;

    logic                    terminal;
    logic                    apply;
    logic                    pend_go;
    logic [DIV_W-1:0]        pend_eff;

    function automatic logic [DIV_W-1:0] eff_period(input logic [DIV_W-1:0] p);
        if (p != '0 && p < DIV_W'(MIN_PERIOD)) begin
            return DIV_W'(MIN_PERIOD);
        end
        return p;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            phase_q       <= 2'b00;
            pos_q         <= '0;
            act_period_q  <= '0;
            act_dir_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_dir_q    <= 1'b0;
            pend_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            phase_q       <= phase_d;
            pos_q         <= pos_d;
            act_period_q  <= act_period_d;
            act_dir_q     <= act_dir_d;
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            pend_dir_q    <= pend_dir_d;
            pend_en_q     <= pend_en_d;
        end
    end

    // A pending command is only taken at an edge boundary, or straight away from IDLE.
    always_comb begin
        terminal = (state_q == S_RUN) && (div_q == '0);
        apply    = pend_valid_q && ((state_q == S_IDLE) || terminal);
        pend_go  = pend_en_q && (pend_period_q != '0);
        state_d  = state_q;
        if (apply) begin
            state_d = pend_go ? S_RUN : S_IDLE;
        end
    end

    always_comb begin
        cmd_ack  = apply;
        step     = terminal;
        running  = (state_q == S_RUN);
        enc_a    = phase_q[1];
        enc_b    = phase_q[0];
        position = pos_q;
    end

    always_comb begin
        pend_eff      = eff_period(pend_period_q);
        div_d         = (state_q == S_RUN) ? div_q - DIV_W'(1) : '0;
        phase_d       = phase_q;
        pos_d         = pos_q;
        act_period_d  = act_period_q;
        act_dir_d     = act_dir_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_dir_d    = pend_dir_q;
        pend_en_d     = pend_en_q;

        // The boundary edge always uses the direction that was active before any new command.
        if (terminal) begin
            if (act_dir_q) begin
                phase_d = {~phase_q[0], phase_q[1]};
                pos_d   = pos_q - POS_W'(1);
            end else begin
                phase_d = {phase_q[0], ~phase_q[1]};
                pos_d   = pos_q + POS_W'(1);
            end
            div_d = act_period_q - DIV_W'(1);
        end

        if (apply) begin
            act_period_d = pend_eff;
            act_dir_d    = pend_dir_q;
            div_d        = pend_go ? pend_eff - DIV_W'(1) : '0;
        end

        if (cmd_valid) begin
            pend_valid_d  = 1'b1;
            pend_period_d = cmd_period;
            pend_dir_d    = cmd_dir;
            pend_en_d     = cmd_en;
        end else if (apply) begin
            pend_valid_d  = 1'b0;
        end
    end

`ifdef QUAD_ENCODER_INDEX_EN
    localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             z_q, z_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            z_q   <= 1'b0;
        end else begin
            idx_q <= idx_d;
            z_q   <= z_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        z_d   = z_q;
        if (terminal) begin
            if (!act_dir_q) begin
                idx_d = (idx_q == IDX_W'(CPR - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                idx_d = (idx_q == '0) ? IDX_W'(CPR - 1) : idx_q - IDX_W'(1);
            end
            z_d = (idx_d == '0);
        end
    end

    assign enc_z = z_q;
`endif

endmodule
